uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 90 +++++++++
 tb/tb_uart_tx_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle between the arbiter and its environment.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][UART_BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]                  req_ready;
  logic                                tx_start;
  logic [UART_BYTE_W-1:0]              tx_data;
  logic                                tx_done;
  logic [IDX_W-1:0]                    grant_id;
  logic                                busy;
  logic                                timeout_err;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  // Walk offsets from farthest to nearest so the nearest match is written last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional tx_done watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q, grant_q, winner;
  logic [UART_BYTE_W-1:0] data_q;
  logic                   found, wd_expire, xfer_end;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .found      (found)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;

  // tx_done in the final count cycle still counts as a normal completion.
  assign wd_expire = (state_q == WAIT_DONE) && !bus.tx_done &&
                     (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if (state_q == START)          wd_cnt_q <= '0;
      else if (state_q == WAIT_DONE) wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign wd_expire       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign xfer_end = (state_q == WAIT_DONE) && (bus.tx_done || wd_expire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (found) state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (xfer_end) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      data_q       <= '0;
    end else begin
      if (state_q == IDLE && found) begin
        grant_q <= winner;
        data_q  <= bus.req_data[winner];
      end
      if (xfer_end) last_grant_q <= grant_q;
    end
  end

  assign bus.tx_start  = (state_q == START);
  assign bus.req_ready = bus.tx_start ? (NUM_REQ'(1) << grant_q) : '0;
  assign bus.tx_data   = data_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TMO     = 50;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   last;
  logic [NUM_REQ-1:0][7:0] rd;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: scan requesters in order last+1, last+2, ... modulo NUM_REQ.
  function automatic int rr_model(input logic [NUM_REQ-1:0] v, input int lg);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (lg + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // One arbitration attempt starting from IDLE; w = granted index or -1.
  task automatic do_xfer(input logic [NUM_REQ-1:0] mask, input int dly,
                         input bit done_in_start, input bit churn, output int w);
    logic [7:0] exp_data;
    w = rr_model(mask, last);
    bus.req_valid = mask;
    bus.req_data  = rd;
    step();
    if (w < 0) begin
      check("idle_no_req_busy", 32'(bus.busy), 32'd0);
      check("idle_no_req_start", 32'(bus.tx_start), 32'd0);
      return;
    end
    exp_data = rd[w];
    check("start_pulse", 32'(bus.tx_start), 32'd1);
    check("start_ready", 32'(bus.req_ready), 32'(1) << w);
    check("start_grant", 32'(bus.grant_id), 32'(w));
    check("start_data", 32'(bus.tx_data), 32'(exp_data));
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_tmo", 32'(bus.timeout_err), 32'd0);
    bus.req_valid[w] = 1'b0;
    if (done_in_start) bus.tx_done = 1'b1;
    for (int j = 0; j < dly; j++) begin
      step();
      bus.tx_done = 1'b0;
      check("wait_busy", 32'(bus.busy), 32'd1);
      check("wait_ready", 32'(bus.req_ready), 32'd0);
      check("wait_start", 32'(bus.tx_start), 32'd0);
      check("wait_data", 32'(bus.tx_data), 32'(exp_data));
      check("wait_tmo", 32'(bus.timeout_err), 32'd0);
      if (churn) begin
        bus.req_data  = NUM_REQ*8'($urandom);
        bus.req_valid = NUM_REQ'($urandom);
      end
    end
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_data_hold", 32'(bus.tx_data), 32'(exp_data));
    check("done_grant_hold", 32'(bus.grant_id), 32'(w));
    last = w;
  endtask

  initial begin
    int w;
    int seq[5];
    seq = '{0, 1, 2, 3, 0};
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    last          = NUM_REQ - 1;
    step(); step();
    check("rst_start", 32'(bus.tx_start), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_grant", 32'(bus.grant_id), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'd0);
    check("rst_tmo", 32'(bus.timeout_err), 32'd0);
    reset = 1'b0;
    step();

    // Single requester 0 with 'A'
    rd = '0; rd[0] = 8'h41;
    do_xfer(4'b0001, 9, 1'b0, 1'b0, w);
    check("first_grant", 32'(w), 32'd0);

    // All valid: grants rotate from last+1
    for (int i = 0; i < 5; i++) begin
      rd = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      do_xfer(4'b1111, 9, 1'b0, 1'b0, w);
      check("rotate_seq", 32'(w), 32'((seq[i] + 1) % NUM_REQ));
    end

    // Lone continuous requester 2 keeps winning; data churn must not leak
    for (int i = 0; i < 3; i++) begin
      rd = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      do_xfer(4'b0100, 6, 1'b0, 1'b1, w);
      check("lone_req2", 32'(w), 32'd2);
    end

    // tx_done during START is ignored
    rd = {8'h11, 8'h22, 8'h33, 8'h44};
    do_xfer(4'b1000, 4, 1'b1, 1'b0, w);

    // No requests: stays idle
    do_xfer(4'b0000, 0, 1'b0, 1'b0, w);
    check("idle_none", 32'(w), 32'hFFFF_FFFF);

`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int wt;
      rd = {8'h55, 8'h66, 8'h77, 8'h88};
      bus.req_valid = 4'b0011;
      bus.req_data  = rd;
      wt = rr_model(4'b0011, last);
      step();
      check("tmo_start", 32'(bus.tx_start), 32'd1);
      bus.req_valid[wt] = 1'b0;
      for (int j = 1; j <= TMO + 1; j++) begin
        step();
        if (j <= TMO) begin
          check("tmo_quiet", 32'(bus.timeout_err), 32'd0);
          check("tmo_busy", 32'(bus.busy), 32'd1);
        end else begin
          check("tmo_pulse", 32'(bus.timeout_err), 32'd1);
          check("tmo_idle", 32'(bus.busy), 32'd0);
        end
      end
      last = wt;
      do_xfer(4'b0011, 3, 1'b0, 1'b0, w);
      check("tmo_next", 32'(w), 32'((wt == 0) ? 1 : 0));
    end
`endif

    // Reset during WAIT_DONE
    rd = {8'hA3, 8'hB2, 8'hC1, 8'hD0};
    bus.req_valid = 4'b0100;
    bus.req_data  = rd;
    step();
    check("pre_rst_start", 32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    step(); step();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_grant", 32'(bus.grant_id), 32'd0);
    check("mid_rst_data", 32'(bus.tx_data), 32'd0);
    check("mid_rst_start", 32'(bus.tx_start), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    reset = 1'b0;
    last  = NUM_REQ - 1;
    step();
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    rd = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    do_xfer(4'b1111, 5, 1'b0, 1'b0, w);
    check("post_rst_prio0", 32'(w), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      rd = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      do_xfer(NUM_REQ'($urandom_range(0, 15)), $urandom_range(1, 15),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
